// File: rtl/dmem_pkg.sv
// ---- dmem_pkg: shared constants, arbiter state type and address-check helper (rev 1.0) ----
`default_nettype none

package dmem_pkg;

  localparam logic [31:0] DMEM_BASE   = 32'h1001_0000;
  localparam logic [31:0] IMEM_BASE   = 32'h0040_0000;
  localparam int          DMEM_ADDR_W = 11;
  localparam int          PORT_CPU    = 0;
  localparam int          PORT_DBG    = 1;

  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } last_t;

  // Rejects addresses below the window, misaligned, or past the last word.
  function automatic logic map_err(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input int          addr_w);
    logic [31:0] off;
    off = addr - base;
    return (addr < base) || (addr[1:0] != 2'b00) ||
           ((off >> 2) >= (32'd1 << addr_w));
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ---- rr_arb2: two-way round-robin arbiter with fixed-priority override (rev 1.0) ----
`default_nettype none

module rr_arb2
  import dmem_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  last_t last, last_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last <= LAST1;
    else     last <= last_nxt;
  end

  always_comb begin
    gnt      = 2'b00;
    last_nxt = last;
    if (!rst) begin
      if (req == 2'b11) begin
        if (FIXED_PRIO || last == LAST1) gnt = 2'b01;
        else                             gnt = 2'b10;
      end else begin
        gnt = req;
      end
    end
    if (gnt[0])      last_nxt = LAST0;
    else if (gnt[1]) last_nxt = LAST1;
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ---- dmem_arbiter: two-port round-robin arbiter in front of the data memory (rev 1.0) ----
`default_nettype none

module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DMEM_BASE,
  parameter int          ADDR_W     = DMEM_ADDR_W,
  parameter int          FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic              dm_r,
  output logic              dm_w,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata
);

  logic [1:0]  req, gnt, we, acc_err;
  logic        sel, access;
  logic [31:0] sel_addr, sel_off, sel_wdata;
  logic        rvalid_q [2];
  logic        err_q    [2];
  logic [31:0] rdata_q  [2];

  assign req        = {m1_req, m0_req};
  assign we         = {m1_we, m0_we};
  assign acc_err[0] = map_err(m0_addr, BASE_ADDR, ADDR_W);
  assign acc_err[1] = map_err(m1_addr, BASE_ADDR, ADDR_W);
  assign m0_gnt     = gnt[PORT_CPU];
  assign m1_gnt     = gnt[PORT_DBG];

  rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO != 0)
  ) u_arb (
    .clk(clk),
    .rst(rst),
    .req(req),
    .gnt(gnt)
  );

  // Errored grants still consume the slot but never touch the memory.
  always_comb begin
    sel       = gnt[PORT_DBG];
    sel_addr  = sel ? m1_addr  : m0_addr;
    sel_wdata = sel ? m1_wdata : m0_wdata;
    sel_off   = sel_addr - BASE_ADDR;
    access    = (|gnt) && !acc_err[sel];
    dm_r      = access && !we[sel];
    dm_w      = access &&  we[sel];
    dm_addr   = access ? ADDR_W'(sel_off >> 2) : '0;
    dm_wdata  = access ? sel_wdata : 32'h0;
  end

  for (genvar p = 0; p < 2; p++) begin : g_resp
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rvalid_q[p] <= 1'b0;
        err_q[p]    <= 1'b0;
        rdata_q[p]  <= 32'h0;
      end else if (gnt[p] && acc_err[p]) begin
        rvalid_q[p] <= 1'b1;
        err_q[p]    <= 1'b1;
      end else if (gnt[p] && !we[p]) begin
        rvalid_q[p] <= 1'b1;
        err_q[p]    <= 1'b0;
        rdata_q[p]  <= dm_rdata;
      end else begin
        rvalid_q[p] <= 1'b0;
        err_q[p]    <= 1'b0;
      end
    end
  end

  assign m0_rvalid = rvalid_q[0];
  assign m0_err    = err_q[0];
  assign m0_rdata  = rdata_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m1_err    = err_q[1];
  assign m1_rdata  = rdata_q[1];

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ---- tb_dmem_arbiter: randomized scoreboard bench for dmem_arbiter (rev 1.0) ----
`default_nettype none

module tb_dmem_arbiter;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          AW    = 11;
  localparam int          DEPTH = 2048;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, dm_r, dm_w;
  logic [31:0] m0_rdata, m1_rdata, dm_wdata, dm_rdata;
  logic [AW-1:0] dm_addr;
  logic fp_m0_gnt, fp_m0_rvalid, fp_m0_err, fp_m1_gnt, fp_m1_rvalid, fp_m1_err;
  logic fp_dm_r, fp_dm_w;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_dm_wdata;
  logic [31:0] fp_dm_rdata = 32'h0;
  logic [AW-1:0] fp_dm_addr;

  always #5 clk = ~clk;

  dmem_arbiter #(.BASE_ADDR(BASE), .ADDR_W(AW), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .dm_r(dm_r), .dm_w(dm_w), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  dmem_arbiter #(.BASE_ADDR(BASE), .ADDR_W(AW), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata), .m0_err(fp_m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata), .m1_err(fp_m1_err),
    .dm_r(fp_dm_r), .dm_w(fp_dm_w), .dm_addr(fp_dm_addr), .dm_wdata(fp_dm_wdata),
    .dm_rdata(fp_dm_rdata)
  );

  // Memory behind the main instance: combinational read, write on the clock edge.
  logic [31:0] mem [DEPTH];
  assign dm_rdata = mem[dm_addr];
  always @(posedge clk) if (dm_w) mem[dm_addr] <= dm_wdata;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_rd [2] = '{32'h0, 32'h0};
  int          last_m = 1;
  bit          expq0 [$];
  bit          expq1 [$];
  bit   [1:0]  fp_ev = 2'b00, fp_ee = 2'b00;

  function automatic bit map_err(logic [31:0] a);
    if (a < BASE) return 1'b1;
    if (a % 4 != 0) return 1'b1;
    return ((a - BASE) / 4) >= DEPTH;
  endfunction

  function automatic logic [31:0] word_of(logic [31:0] a);
    return (a - BASE) / 4;
  endfunction

  function automatic req_t cur_req(int p);
    req_t c;
    if (p == 1) c = '{m1_we, m1_addr, m1_wdata};
    else        c = '{m0_we, m0_addr, m0_wdata};
    return c;
  endfunction

  task automatic resp_chk(int p, logic v, logic e, logic [31:0] d);
    bit have, x;
    have = 1'b0;
    x    = 1'b0;
    if (p == 0 && expq0.size() > 0) begin x = expq0.pop_front(); have = 1'b1; end
    if (p == 1 && expq1.size() > 0) begin x = expq1.pop_front(); have = 1'b1; end
    chk($sformatf("rvalid%0d", p), v, have);
    if (have && v === 1'b1) chk($sformatf("err%0d", p), e, x);
    chk($sformatf("rdata%0d", p), d, last_rd[p]);
  endtask

  task automatic bus_chk(string tag, logic [1:0] eg, logic r, logic w, logic [AW-1:0] a,
                         logic [31:0] wd, output bit e, output req_t c);
    e = 1'b0;
    c = cur_req(eg[1] ? 1 : 0);
    if (eg == 2'b00) begin
      chk({tag, "_idle_r"}, r, 0);
      chk({tag, "_idle_w"}, w, 0);
      chk({tag, "_idle_addr"}, a, 0);
      chk({tag, "_idle_wdata"}, wd, 0);
    end else begin
      e = map_err(c.addr);
      if (e) begin
        chk({tag, "_err_r"}, r, 0);
        chk({tag, "_err_w"}, w, 0);
      end else begin
        chk({tag, "_addr"}, a, word_of(c.addr));
        chk({tag, "_r"}, r, !c.we);
        chk({tag, "_w"}, w, c.we);
        chk({tag, "_wdata"}, wd, c.wdata);
      end
    end
  endtask

  // Monitor: retire last cycle's expected responses, then model this cycle's grant.
  always @(negedge clk) begin
    logic [1:0] rq, eg, egf;
    bit e;
    req_t c;
    int p;
    if (rst) begin
      expq0.delete();
      expq1.delete();
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
      last_m     = 1;
      fp_ev      = 2'b00;
      fp_ee      = 2'b00;
    end else begin
      resp_chk(0, m0_rvalid, m0_err, m0_rdata);
      resp_chk(1, m1_rvalid, m1_err, m1_rdata);
      chk("fp_rvalid0", fp_m0_rvalid, fp_ev[0]);
      chk("fp_rvalid1", fp_m1_rvalid, fp_ev[1]);
      if (fp_ev[0]) chk("fp_err0", fp_m0_err, fp_ee[0]);
      if (fp_ev[1]) chk("fp_err1", fp_m1_err, fp_ee[1]);
      chk("fp_rdata0", fp_m0_rdata, 0);
      chk("fp_rdata1", fp_m1_rdata, 0);

      rq  = {m1_req, m0_req};
      eg  = (rq == 2'b11) ? ((last_m == 1) ? 2'b01 : 2'b10) : rq;
      egf = rq[0] ? 2'b01 : rq;
      chk("gnt", {m1_gnt, m0_gnt}, eg);
      chk("fp_gnt", {fp_m1_gnt, fp_m0_gnt}, egf);

      bus_chk("bus", eg, dm_r, dm_w, dm_addr, dm_wdata, e, c);
      if (eg != 2'b00) begin
        p = eg[1] ? 1 : 0;
        if (e || !c.we) begin
          if (!e) last_rd[p] = ref_mem[word_of(c.addr)];
          if (p == 0) expq0.push_back(e);
          else        expq1.push_back(e);
        end else begin
          ref_mem[word_of(c.addr)] = c.wdata;
        end
        last_m = p;
      end

      bus_chk("fp_bus", egf, fp_dm_r, fp_dm_w, fp_dm_addr, fp_dm_wdata, e, c);
      fp_ev = 2'b00;
      fp_ee = 2'b00;
      if (egf != 2'b00) begin
        p = egf[1] ? 1 : 0;
        fp_ev[p] = e || !c.we;
        fp_ee[p] = e;
      end
    end
  end

  // Stimulus driver
  req_t q0 [$];
  req_t q1 [$];
  bit   gap_en = 1'b0;

  task automatic push(int p, bit we, logic [31:0] addr, logic [31:0] wdata);
    req_t x;
    x = '{we, addr, wdata};
    if (p == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  task automatic load(int p);
    req_t x;
    bit idle;
    idle = gap_en && ($urandom_range(0, 3) == 0);
    if (p == 0) begin
      if (!idle && q0.size() > 0) begin
        x = q0.pop_front();
        m0_we = x.we; m0_addr = x.addr; m0_wdata = x.wdata; m0_req = 1'b1;
      end else m0_req = 1'b0;
    end else begin
      if (!idle && q1.size() > 0) begin
        x = q1.pop_front();
        m1_we = x.we; m1_addr = x.addr; m1_wdata = x.wdata; m1_req = 1'b1;
      end else m1_req = 1'b0;
    end
  endtask

  task automatic step();
    bit g0, g1;
    @(negedge clk);
    g0 = m0_gnt;
    g1 = m1_gnt;
    @(posedge clk);
    #1;
    if (!m0_req || g0) load(0);
    if (!m1_req || g1) load(1);
  endtask

  task automatic run_phase();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((q0.size() > 0 || q1.size() > 0 || m0_req || m1_req) && n < 400);
    if (n >= 400) begin
      bad++;
      total++;
      $display("FAIL phase_timeout got=%0d want<400", n);
    end
    step();
    step();
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return BASE - 32'(4 * $urandom_range(1, 4));
      1:       return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
      2:       return BASE + 32'(4 * (DEPTH + $urandom_range(0, 3)));
      3:       return BASE + 32'(4 * $urandom_range(DEPTH - 8, DEPTH - 1));
      default: return BASE + 32'(4 * $urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    m0_req  = 1'b1;
    m0_addr = BASE;
    #1 rst = 1'b1;
    #2;
    chk("rst_gnt0", m0_gnt, 0);
    chk("rst_dm_r", dm_r, 0);
    chk("rst_rvalid0", m0_rvalid, 0);
    chk("rst_rvalid1", m1_rvalid, 0);
    chk("rst_rdata0", m0_rdata, 0);
    chk("rst_rdata1", m1_rdata, 0);
    m0_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Write then read back
    push(0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF);
    push(0, 1'b0, 32'h1001_0008, 32'h0);
    run_phase();

    // Continuous contention
    for (int i = 0; i < 3; i++) begin
      push(0, 1'b0, BASE + 32'(4 * i), 32'h0);
      push(1, 1'b0, BASE + 32'(4 * i + 8), 32'h0);
    end
    run_phase();

    // Out-of-window accesses on port 1, then confirm memory untouched
    push(1, 1'b0, 32'h1000_FFFC, 32'h0);
    push(1, 1'b0, 32'h1001_0002, 32'h0);
    push(1, 1'b0, 32'h1001_2000, 32'h0);
    push(1, 1'b1, 32'h1001_2000, 32'h1234_5678);
    push(1, 1'b0, 32'h1001_0008, 32'h0);
    run_phase();

    // Top word of the window
    push(0, 1'b1, 32'h1001_1FFC, 32'hCAFE_F00D);
    push(0, 1'b0, 32'h1001_1FFC, 32'h0);
    run_phase();

    // Asynchronous reset in the middle of a granted port-1 read
    @(posedge clk);
    #1;
    m1_we = 1'b0; m1_addr = 32'h1001_0008; m1_req = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("midrst_gnt1", m1_gnt, 0);
    chk("midrst_dm_r", dm_r, 0);
    m1_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    push(0, 1'b0, 32'h1001_0008, 32'h0);
    push(1, 1'b0, 32'h1001_0008, 32'h0);
    run_phase();

    // Back-to-back writes to words 0..3, then read them back
    for (int i = 0; i < 4; i++) push(0, 1'b1, BASE + 32'(4 * i), 32'hA5A5_0000 + 32'(i));
    for (int i = 0; i < 4; i++) push(0, 1'b0, BASE + 32'(4 * i), 32'h0);
    run_phase();

    // Randomized traffic with idle gaps
    gap_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      push(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      push(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
    end
    run_phase();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory between the CPU load/store port (port 0) and a second bus master (port 1, debug/DMA loader). It maps 32-bit byte addresses into the memory's word index, grants one access per cycle with round-robin fairness, and returns registered read data with a fixed one-cycle latency. It sits between the CPU/loader and `dmem`, replacing direct address mapping at the computer top level.

## Interface
- `BASE_ADDR`, 32'h10010000, byte address of data-memory word 0
- `ADDR_W`, 11, word-index width (memory holds 2^ADDR_W words)
- `FIXED_PRIO`, 0, 1 = port 0 always wins, 0 = round-robin

- `clk` in 1 single clock
- `rst` in 1 asynchronous, active-high reset
- `m0_req`, `m1_req` in 1 access request, held until granted
- `m0_we`, `m1_we` in 1 1 = write, 0 = read
- `m0_addr`, `m1_addr` in 32 byte address
- `m0_wdata`, `m1_wdata` in 32 write data
- `m0_gnt`, `m1_gnt` out 1 request accepted this cycle
- `m0_rvalid`, `m1_rvalid` out 1 response valid (reads and errored accesses)
- `m0_rdata`, `m1_rdata` out 32 registered read data
- `m0_err`, `m1_err` out 1 access rejected (qualified by rvalid)
- `dm_r`, `dm_w` out 1 memory read/write strobes
- `dm_addr` out ADDR_W word index
- `dm_wdata` out 32 memory write data
- `dm_rdata` in 32 memory combinational read data

## Operation
- Arbiter state `last` (LAST0/LAST1) records the most recently granted port. Reset value: LAST1, so port 0 wins the first contention.
- One request only: grant it. Both request: grant the port not equal to `last` (FIXED_PRIO=1: always port 0). After any grant, `last` ← granted port. No grant: `last` holds.
- Mapping: offset = addr − BASE_ADDR (32-bit); word = offset >> 2. Error if addr < BASE_ADDR, addr[1:0] ≠ 0, or (offset >> 2) ≥ 2^ADDR_W.
- Granted, no error: drive `dm_addr` = word[ADDR_W-1:0], `dm_wdata`, and `dm_w` = we, `dm_r` = ~we.
- Granted with error: `gnt` still asserted, `dm_r`/`dm_w` held 0, memory untouched.
- Response register per port: on a granted read, `rdata` ← `dm_rdata`, `rvalid` ← 1, `err` ← 0. On an errored access (read or write), `rvalid` ← 1, `err` ← 1, `rdata` holds. Successful writes produce no response. Otherwise `rvalid` ← 0, `err` ← 0. `rdata` holds its last value between reads.
- Idle (no request): `dm_r` = `dm_w` = 0, `dm_addr` = 0, `dm_wdata` = 0.

## Timing
- `gnt`, `dm_*` strobes and `dm_addr` are combinational from requests and `last`, with zero latency.
- Write commits at the rising edge ending the grant cycle.
- Read response: `rvalid`/`rdata`/`err` one cycle after `gnt`.
- A requester may change `addr`/`we`/`wdata` or drop `req` only after the edge at which `gnt` was high. Behaviour is undefined if `req` drops before grant.
- A lone requester can be granted every cycle (back-to-back). Under continuous dual requests, grants alternate 0,1,0,1…
- Reset (asynchronous, any time): `last` = LAST1; all `rvalid`, `err` = 0; all `rdata` = 0. `gnt` and `dm_r`/`dm_w` are forced to 0 while `rst` is high. An in-flight read response is dropped.

## Structure
- Package `dmem_pkg`: `DMEM_BASE` = 32'h10010000, `IMEM_BASE` = 32'h00400000, `DMEM_ADDR_W` = 11, port-index constants `PORT_CPU` = 0 and `PORT_DBG` = 1.
- Sub-module `rr_arb2`: 2-way round-robin with `last` register and fixed-priority override. Mapping, muxing and response registers live in `dmem_arbiter`.

## Test plan
- Reset, then m0 write 32'hDEADBEEF at 32'h10010008, then read it back → dm_addr = 2, m0_rvalid one cycle after gnt, m0_rdata = 32'hDEADBEEF, m0_err = 0.
- Both ports request reads continuously for 6 cycles → first grant to m0, then alternating grants, exactly 3 per port. Repeat with FIXED_PRIO=1 → all 6 grants to m0.
- m1 reads 32'h1000FFFC, 32'h10010002 and 32'h10012000 (ADDR_W=11) → each granted, dm_r = 0, m1_rvalid = m1_err = 1 next cycle, memory contents unchanged.
- m0 read at 32'h10011FFC → dm_addr = 2047, valid data, no error (top boundary).
- Assert `rst` asynchronously mid-cycle during a granted m1 read → gnt and dm_r drop immediately, no m1_rvalid afterwards, next contention grants m0.
- m0 single-cycle writes to words 0..3 on consecutive cycles → 4 grants in 4 cycles, read-back returns all 4 values.
